// File: rtl/player_bullet_ctrl_if.sv
// Interface between the player bullet controller and its neighbours
// (frame timing, fire button, player position, hit judge).
interface player_bullet_ctrl_if;
   logic       frame_tick;
   logic       fire_btn;
   logic [9:0] p_x;
   logic [9:0] p_y;
   logic       hit_clr;
   logic [9:0] b_x;
   logic [9:0] b_y;
   logic       mybullet_en;
   logic       fire_pulse;

   modport master (
      output frame_tick, fire_btn, p_x, p_y, hit_clr,
      input  b_x, b_y, mybullet_en, fire_pulse
   );

   modport slave (
      input  frame_tick, fire_btn, p_x, p_y, hit_clr,
      output b_x, b_y, mybullet_en, fire_pulse
   );
endinterface

// File: rtl/player_bullet_ctrl.sv
// Player's single bullet: spawn on fire, climb once per frame, retire on hit or
// top edge, then frame-counted cooldown. PLAYER_BULLET_AUTOFIRE_EN: held fire re-spawns.
module player_bullet_ctrl #(
   parameter int unsigned BULLET_SPEED    = 4,
   parameter int unsigned BULLET_H        = 10,
   parameter int unsigned GUN_OFFSET_X    = 20,
   parameter int unsigned COOLDOWN_FRAMES = 8
) (
   input logic                 clk,
   input logic                 rst,
   player_bullet_ctrl_if.slave bus
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_FLYING   = 2'd1;
   localparam logic [1:0] ST_COOLDOWN = 2'd2;

   localparam int unsigned CNT_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

   localparam logic [9:0]       SPEED   = 10'(BULLET_SPEED);
   localparam logic [9:0]       SPAWN_H = 10'(BULLET_H);
   localparam logic [9:0]       GUN_X   = 10'(GUN_OFFSET_X);
   localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_FRAMES);
   localparam logic [CNT_W-1:0] CD_ONE  = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [2:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;
   logic [9:0]       b_x_q, b_x_d;
   logic [9:0]       b_y_q, b_y_d;
   logic             en_q, en_d;
   logic             fire_pulse_q, fire_pulse_d;
   logic             spawn_req;
   logic [9:0]       spawn_y;

   // sync_q[0]/[1] form the synchroniser, sync_q[2] is the edge-detect history.
`ifdef PLAYER_BULLET_AUTOFIRE_EN
   assign spawn_req = sync_q[1];
`else
   assign spawn_req = sync_q[1] & ~sync_q[2];
`endif

   assign spawn_y = (bus.p_y < SPAWN_H) ? '0 : (bus.p_y - SPAWN_H);

   always_comb begin
      sync_d       = {sync_q[1:0], bus.fire_btn};
      state_d      = state_q;
      cd_cnt_d     = cd_cnt_q;
      b_x_d        = b_x_q;
      b_y_d        = b_y_q;
      en_d         = en_q;
      fire_pulse_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (spawn_req) begin
               b_x_d        = bus.p_x + GUN_X;
               b_y_d        = spawn_y;
               en_d         = 1'b1;
               fire_pulse_d = 1'b1;
               state_d      = ST_FLYING;
            end
         end

         ST_FLYING: begin
            // A hit outranks movement: position freezes where the judge saw it.
            if (bus.hit_clr) begin
               en_d     = 1'b0;
               cd_cnt_d = CD_LOAD;
               state_d  = ST_COOLDOWN;
            end else if (bus.frame_tick) begin
               if (b_y_q < SPEED) begin
                  en_d     = 1'b0;
                  b_y_d    = '0;
                  cd_cnt_d = CD_LOAD;
                  state_d  = ST_COOLDOWN;
               end else begin
                  b_y_d = b_y_q - SPEED;
               end
            end
         end

         ST_COOLDOWN: begin
            if (cd_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else if (bus.frame_tick) begin
               cd_cnt_d = cd_cnt_q - CD_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sync_q       <= '0;
         cd_cnt_q     <= '0;
         b_x_q        <= '0;
         b_y_q        <= '0;
         en_q         <= 1'b0;
         fire_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         cd_cnt_q     <= cd_cnt_d;
         b_x_q        <= b_x_d;
         b_y_q        <= b_y_d;
         en_q         <= en_d;
         fire_pulse_q <= fire_pulse_d;
      end
   end

   assign bus.b_x         = b_x_q;
   assign bus.b_y         = b_y_q;
   assign bus.mybullet_en = en_q;
   assign bus.fire_pulse  = fire_pulse_q;

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// Self-checking bench for player_bullet_ctrl: directed scenarios then random
// traffic, all compared against a behavioural model of the bullet's life cycle.
module tb_player_bullet_ctrl;

   localparam int SPEED = 4;
   localparam int HOFF  = 10;
   localparam int GUNX  = 20;
   localparam int COOL  = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   player_bullet_ctrl_if bus ();

   player_bullet_ctrl #(
      .BULLET_SPEED   (SPEED),
      .BULLET_H       (HOFF),
      .GUN_OFFSET_X   (GUNX),
      .COOLDOWN_FRAMES(COOL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int dut_pulses = 0;

   // Model: bullet life cycle as plain integers; fire_btn history as a delay line.
   int m_live, m_bx, m_by, m_pulse, m_spawns;
   int m_cooling, m_frames_left;
   int m_hist[3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_live = 0; m_bx = 0; m_by = 0; m_pulse = 0;
      m_cooling = 0; m_frames_left = 0;
      foreach (m_hist[i]) m_hist[i] = 0;
   endtask

   task automatic retire();
      m_live = 0;
      m_cooling = 1;
      m_frames_left = COOL;
   endtask

   task automatic model_edge();
      int rising, want;
      rising = (m_hist[1] == 1 && m_hist[2] == 0) ? 1 : 0;
`ifdef PLAYER_BULLET_AUTOFIRE_EN
      want = m_hist[1];
`else
      want = rising;
`endif
      m_pulse = 0;
      if (m_cooling == 1) begin
         if (m_frames_left == 0) m_cooling = 0;
         else if (bus.frame_tick) m_frames_left = m_frames_left - 1;
      end else if (m_live == 1) begin
         if (bus.hit_clr) retire();
         else if (bus.frame_tick) begin
            if (m_by < SPEED) begin
               m_by = 0;
               retire();
            end else begin
               m_by = m_by - SPEED;
            end
         end
      end else if (want == 1) begin
         m_bx = (int'(bus.p_x) + GUNX) % 1024;
         m_by = (int'(bus.p_y) >= HOFF) ? int'(bus.p_y) - HOFF : 0;
         m_live = 1;
         m_pulse = 1;
         m_spawns++;
      end
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = int'(bus.fire_btn);
   endtask

   task automatic check_all(input string tag);
      check({tag, "_bx"},    32'(bus.b_x),         32'(m_bx));
      check({tag, "_by"},    32'(bus.b_y),         32'(m_by));
      check({tag, "_en"},    32'(bus.mybullet_en), 32'(m_live));
      check({tag, "_pulse"}, 32'(bus.fire_pulse),  32'(m_pulse));
      if (bus.fire_pulse === 1'b1) dut_pulses++;
   endtask

   task automatic tick(input bit ft, input bit fb, input bit hc);
      bus.frame_tick = ft;
      bus.fire_btn   = fb;
      bus.hit_clr    = hc;
      @(posedge clk);
      model_edge();
      #1;
      check_all("step");
   endtask

   task automatic wait_model_idle(input string tag);
      int n;
      n = 0;
      while ((m_live == 1 || m_cooling == 1) && n < 600) begin
         tick(1'b1, 1'b0, 1'b0);
         n++;
      end
      tick(1'b0, 1'b0, 1'b0);
      check({tag, "_idle_bound"}, 32'(n < 600), 32'd1);
   endtask

   task automatic fire_and_spawn();
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, p0, spawns_before;
      bit fb;

      bus.frame_tick = 1'b0;
      bus.fire_btn   = 1'b0;
      bus.hit_clr    = 1'b0;
      bus.p_x        = 10'd100;
      bus.p_y        = 10'd400;
      m_spawns = 0;
      model_reset();

      // Reset state
      #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // T1: spawn three clocks after the press
      tick(1'b0, 1'b1, 1'b0);
      check("t1_no_early_en", 32'(bus.mybullet_en), 32'd0);
      tick(1'b0, 1'b0, 1'b0);
      check("t1_no_early_pulse", 32'(bus.fire_pulse), 32'd0);
      tick(1'b0, 1'b0, 1'b0);
      check("t1_bx", 32'(bus.b_x), 32'd120);
      check("t1_by", 32'(bus.b_y), 32'd390);
      check("t1_en", 32'(bus.mybullet_en), 32'd1);
      check("t1_pulse", 32'(bus.fire_pulse), 32'd1);
      tick(1'b0, 1'b0, 1'b0);
      check("t1_pulse_one_clk", 32'(bus.fire_pulse), 32'd0);

      // T2: climb, then retire at the top edge
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
      check("t2_by_370", 32'(bus.b_y), 32'd370);
      n = 0;
      while (bus.mybullet_en === 1'b1 && n < 200) begin
         tick(1'b1, 1'b0, 1'b0);
         n++;
      end
      check("t2_retire_bound", 32'(n < 200), 32'd1);
      check("t2_top_by", 32'(bus.b_y), 32'd0);
      check("t2_top_en", 32'(bus.mybullet_en), 32'd0);
      for (int i = 0; i < COOL; i++) tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);

      // T3: hit coincident with frame tick at b_y=200; presses during cooldown dropped
      bus.p_y = 10'd410;
      fire_and_spawn();
      check("t3_spawn_by", 32'(bus.b_y), 32'd400);
      for (int i = 0; i < 50; i++) tick(1'b1, 1'b0, 1'b0);
      check("t3_by_200", 32'(bus.b_y), 32'd200);
      tick(1'b1, 1'b0, 1'b1);
      check("t3_hit_en", 32'(bus.mybullet_en), 32'd0);
      check("t3_hit_by", 32'(bus.b_y), 32'd200);
      p0 = dut_pulses;
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 1'b1, 1'b1);
         tick(1'b0, 1'b0, 1'b0);
      end
      check("t3_no_cooldown_fire", 32'(dut_pulses - p0), 32'd0);
      wait_model_idle("t3");

      // T4: spawn near top clamps to 0, first tick retires
      bus.p_y = 10'd5;
      fire_and_spawn();
      check("t4_clamp_by", 32'(bus.b_y), 32'd0);
      check("t4_clamp_en", 32'(bus.mybullet_en), 32'd1);
      tick(1'b1, 1'b0, 1'b0);
      check("t4_retire_en", 32'(bus.mybullet_en), 32'd0);
      wait_model_idle("t4");

      // T5: asynchronous reset mid-flight
      bus.p_y = 10'd400;
      fire_and_spawn();
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("t5_async_en", 32'(bus.mybullet_en), 32'd0);
      check("t5_async_bx", 32'(bus.b_x), 32'd0);
      check("t5_async_by", 32'(bus.b_y), 32'd0);
      check("t5_async_pulse", 32'(bus.fire_pulse), 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      bus.p_x = 10'd1010;
      fire_and_spawn();
      check("t5_after_bx_wrap", 32'(bus.b_x), 32'd6);
      check("t5_after_en", 32'(bus.mybullet_en), 32'd1);
      tick(1'b0, 1'b0, 1'b1);
      wait_model_idle("t5");

      // T6: fire held for 40 frames
      bus.p_x = 10'd100;
      bus.p_y = 10'd50;
      p0 = dut_pulses;
      spawns_before = m_spawns;
      for (int f = 0; f < 40; f++) begin
         tick(1'b1, 1'b1, 1'b0);
         for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
      end
      check("t6_spawns_vs_model", 32'(dut_pulses - p0), 32'(m_spawns - spawns_before));
`ifdef PLAYER_BULLET_AUTOFIRE_EN
      check("t6_autofire_repeats", 32'((dut_pulses - p0) >= 2), 32'd1);
`else
      check("t6_single_spawn", 32'(dut_pulses - p0), 32'd1);
`endif
      tick(1'b0, 1'b0, 1'b0);
      wait_model_idle("t6");

      // Random traffic
      fb = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) fb = ~fb;
         if ($urandom_range(0, 15) == 0) begin
            bus.p_x = 10'($urandom);
            bus.p_y = 10'($urandom);
         end
         tick(1'($urandom_range(0, 3) == 0), fb, 1'($urandom_range(0, 15) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
